// File: rtl/window_pkg.sv
// Shared constants and helpers for the K x K sliding-window generator.
package window_pkg;

  localparam int BORDER_ZERO = 0;
  localparam int BORDER_REPL = 1;

  // Minimum 1 so single-entry memories still get an address bit.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return (r == 0) ? 1 : r;
  endfunction

  // Raster index of tap (r,c); tap 0 is top-left and lands in the MSBs.
  function automatic int tap_idx(input int r, input int c, input int win);
    return r * win + c;
  endfunction

endpackage

// File: rtl/line_buffer_ram.sv
// Simple dual-port line RAM, read-first, one synchronous read and one write port.
module line_buffer_ram
  import window_pkg::*;
#(
  parameter int DEPTH = 864,
  parameter int WIDTH = 16,
  parameter int AW    = clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/window_k_k_gen.sv
// K x K sliding-window generator: line RAM + column history feed a border mux,
// giving one registered window per accepted pixel, two cycles after ivalid.
module window_k_k_gen
  import window_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int WIN    = 3,
  parameter int LINE_W = 864,
  parameter int BORDER = BORDER_ZERO
) (
  input  logic                      iclk,
  input  logic                      rst_i,
  input  logic                      ivalid,
  input  logic                      isof,
  input  logic [DATA_W-1:0]         idata,
  output logic                      ovalid,
  output logic                      osof,
  output logic                      oin,
  output logic [WIN*WIN*DATA_W-1:0] odata_win,
  output logic [DATA_W-1:0]         odata
);

  localparam int H      = (WIN - 1) / 2;
  localparam int NL     = WIN - 1;
  localparam int XW     = clog2(LINE_W);
  localparam int YW     = 16;
  localparam int STAGES = 2;

  typedef logic [WIN-1:0][DATA_W-1:0] col_t;

  logic [XW-1:0]            x_q, x_d, px, px1_q;
  logic [YW-1:0]            y_q, y_d, py, py1_q;
  logic                     sof1_q;
  logic [DATA_W-1:0]        pix1_q;
  logic [STAGES:1]          vld_pipe_q;
  logic [NL*DATA_W-1:0]     rd_line, wr_line;
  col_t                     cur_col;
  col_t [NL-1:0]            hist_q;
  col_t [WIN-1:0]           raw, csel;
  logic [WIN*WIN*DATA_W-1:0] win_d;
  logic [DATA_W-1:0]        ctr_d, tap;
  int                       col_lo, row_lo;

  // isof relocates the current pixel, so the address is resolved before the RAM read.
  always_comb begin
    px  = isof ? '0 : x_q;
    py  = isof ? '0 : y_q;
    x_d = x_q;
    y_d = y_q;
    if (ivalid) begin
      if (px == XW'(LINE_W - 1)) begin
        x_d = '0;
        y_d = (py == '1) ? py : py + 1'b1;
      end else begin
        x_d = px + 1'b1;
        y_d = py;
      end
    end
  end

  always_ff @(posedge iclk) begin
    if (rst_i) begin
      x_q        <= '0;
      y_q        <= '0;
      vld_pipe_q <= '0;
      px1_q      <= '0;
      py1_q      <= '0;
      sof1_q     <= 1'b0;
      pix1_q     <= '0;
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      vld_pipe_q <= {vld_pipe_q[STAGES-1:1], ivalid};
      if (ivalid) begin
        px1_q  <= px;
        py1_q  <= py;
        sof1_q <= isof;
        pix1_q <= idata;
      end
    end
  end

  // Lines cascade one slot deeper; the write lands a cycle after the read at the same column.
  assign wr_line = {rd_line[(NL-1)*DATA_W-1:0], pix1_q};

  line_buffer_ram #(.DEPTH(LINE_W), .WIDTH(NL*DATA_W)) u_lb (
    .clk_i   (iclk),
    .we_i    (vld_pipe_q[1]),
    .waddr_i (px1_q),
    .wdata_i (wr_line),
    .re_i    (ivalid),
    .raddr_i (px),
    .rdata_o (rd_line)
  );

  always_comb begin
    cur_col        = '0;
    cur_col[WIN-1] = pix1_q;
    for (int k = 0; k < NL; k++) cur_col[NL-1-k] = rd_line[k*DATA_W +: DATA_W];
  end

  always_ff @(posedge iclk) begin
    if (vld_pipe_q[1]) hist_q <= {cur_col, hist_q[NL-1:1]};
  end

  assign raw = {cur_col, hist_q};

  // Lowest in-frame column/row index; taps below it are clamped or zeroed.
  always_comb begin
    col_lo = (int'(px1_q) >= NL) ? 0 : NL - int'(px1_q);
    row_lo = (int'(py1_q) >= NL) ? 0 : NL - int'(py1_q);
    csel   = raw;
    for (int c = 0; c < WIN; c++)
      for (int s = 0; s < WIN; s++)
        if (s == ((c < col_lo) ? col_lo : c)) csel[c] = raw[s];
    win_d = '0;
    ctr_d = '0;
    tap   = '0;
    for (int r = 0; r < WIN; r++) begin
      for (int c = 0; c < WIN; c++) begin
        tap = '0;
        for (int s = 0; s < WIN; s++)
          if (s == ((r < row_lo) ? row_lo : r)) tap = csel[c][s];
        if (BORDER != BORDER_REPL && (c < col_lo || r < row_lo)) tap = '0;
        win_d[(WIN*WIN-1-tap_idx(r, c, WIN))*DATA_W +: DATA_W] = tap;
        if (r == H && c == H) ctr_d = tap;
      end
    end
  end

  assign ovalid = vld_pipe_q[STAGES];

  always_ff @(posedge iclk) begin
    if (rst_i) begin
      osof      <= 1'b0;
      oin       <= 1'b0;
      odata_win <= '0;
      odata     <= '0;
    end else if (vld_pipe_q[1]) begin
      osof      <= sof1_q;
      oin       <= (px1_q >= XW'(H)) && (py1_q >= YW'(H));
      odata_win <= win_d;
      odata     <= ctr_d;
    end
  end

endmodule

// File: tb/tb_window_k_k_gen.sv
// Bench for window_k_k_gen: zero-fill and replicate instances fed the same stream,
// checked against an image-based reference and hand-computed window tables.
module tb_window_k_k_gen;

  localparam int DW  = 8;
  localparam int WIN = 3;
  localparam int LW  = 8;
  localparam int WB  = WIN * WIN * DW;

  logic iclk = 1'b0;
  always #5 iclk = ~iclk;

  logic          rst_i = 1'b1, ivalid = 1'b0, isof = 1'b0;
  logic [DW-1:0] idata = '0;
  logic          ov_z, sof_z, in_z, ov_r, sof_r, in_r;
  logic [WB-1:0] w_z, w_r;
  logic [DW-1:0] od_z, od_r;

  window_k_k_gen #(.DATA_W(DW), .WIN(WIN), .LINE_W(LW), .BORDER(0)) u_z (
    .iclk(iclk), .rst_i(rst_i), .ivalid(ivalid), .isof(isof), .idata(idata),
    .ovalid(ov_z), .osof(sof_z), .oin(in_z), .odata_win(w_z), .odata(od_z));

  window_k_k_gen #(.DATA_W(DW), .WIN(WIN), .LINE_W(LW), .BORDER(1)) u_r (
    .iclk(iclk), .rst_i(rst_i), .ivalid(ivalid), .isof(isof), .idata(idata),
    .ovalid(ov_r), .osof(sof_r), .oin(in_r), .odata_win(w_r), .odata(od_r));

  typedef struct { int stamp; int x; int y; logic [81:0] ez; logic [81:0] er; } exp_t;
  typedef struct { int x; int y; int dut; logic [81:0] res; string nm; } vec_t;

  exp_t        q[$];
  vec_t        tab[8];
  logic [7:0]  img [64][8];
  logic [81:0] cap [2][2][8][8];
  int nchk = 0, nerr = 0, cyc = 0, mx = 0, my = 0, nin = 0, nout = 0, slot = 0;
  bit cap_en = 1'b0;

  task automatic check(input string nm, input logic [81:0] act, input logic [81:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: pixel (tx,ty) of the current frame with border rule applied.
  function automatic logic [7:0] mpix(input int tx, input int ty, input bit repl);
    if (repl) begin
      if (tx < 0) tx = 0;
      if (ty < 0) ty = 0;
    end else if (tx < 0 || ty < 0) begin
      return 8'h00;
    end
    return img[ty][tx];
  endfunction

  function automatic logic [71:0] mwin(input int x, input int y, input bit repl);
    logic [71:0] res;
    res = '0;
    for (int r = 0; r < WIN; r++)
      for (int c = 0; c < WIN; c++)
        res[(8 - (r*WIN + c))*8 +: 8] = mpix(x - 2 + c, y - 2 + r, repl);
    return res;
  endfunction

  always @(posedge iclk) begin
    exp_t e;
    bit   ev;
    if (rst_i) begin
      q.delete();
      mx = 0;
      my = 0;
    end else if (ivalid) begin
      if (isof) begin mx = 0; my = 0; end
      img[my][mx] = idata;
      e.stamp = cyc; e.x = mx; e.y = my;
      e.ez = {isof, (mx >= 1 && my >= 1), mpix(mx-1, my-1, 1'b0), mwin(mx, my, 1'b0)};
      e.er = {isof, (mx >= 1 && my >= 1), mpix(mx-1, my-1, 1'b1), mwin(mx, my, 1'b1)};
      q.push_back(e);
      nin++;
      if (mx == LW - 1) begin mx = 0; if (my < 63) my++; end
      else mx++;
    end
    #1;
    ev = (q.size() > 0) && (q[0].stamp == cyc - 1);
    if (ov_z) nout++;
    if (ev || ov_z || ov_r) begin
      check_int("ovalid_z", int'(ov_z), int'(ev));
      check_int("ovalid_r", int'(ov_r), int'(ev));
      if (ev) begin
        e = q.pop_front();
        check("win_z", {sof_z, in_z, od_z, w_z}, e.ez);
        check("win_r", {sof_r, in_r, od_r, w_r}, e.er);
        if (cap_en && e.y < 8) begin
          cap[slot][0][e.y][e.x] = {sof_z, in_z, od_z, w_z};
          cap[slot][1][e.y][e.x] = {sof_r, in_r, od_r, w_r};
        end
      end
    end
    cyc++;
  end

  task automatic drive(input bit v, input bit s, input logic [7:0] d);
    @(negedge iclk);
    ivalid = v; isof = s; idata = d;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic frame(input bit gapped, input int rows, input logic [7:0] base);
    for (int y = 0; y < rows; y++)
      for (int x = 0; x < LW; x++) begin
        if (gapped) repeat ($urandom_range(1, 3)) drive(1'b0, 1'b0, 8'h00);
        drive(1'b1, (x == 0 && y == 0), base + 8'(16*y + x));
      end
  endtask

  initial begin
    int bad;
    // {osof, oin, odata, window rows top..bottom} for p(x,y) = 16y + x
    tab[0] = '{5, 3, 0, {1'b0, 1'b1, 8'h24, 72'h13_14_15_23_24_25_33_34_35}, "int_5_3_zero"};
    tab[1] = '{0, 0, 0, {1'b1, 1'b0, 8'h00, 72'h00_00_00_00_00_00_00_00_00}, "corner_0_0_zero"};
    tab[2] = '{1, 1, 1, {1'b0, 1'b1, 8'h00, 72'h00_00_01_00_00_01_10_10_11}, "corner_1_1_repl"};
    tab[3] = '{7, 4, 1, {1'b0, 1'b1, 8'h36, 72'h25_26_27_35_36_37_45_46_47}, "edge_7_4_repl"};
    tab[4] = '{2, 0, 0, {1'b0, 1'b0, 8'h00, 72'h00_00_00_00_00_00_00_01_02}, "top_2_0_zero"};
    tab[5] = '{2, 0, 1, {1'b0, 1'b0, 8'h01, 72'h00_01_02_00_01_02_00_01_02}, "top_2_0_repl"};
    tab[6] = '{0, 3, 1, {1'b0, 1'b0, 8'h20, 72'h10_10_10_20_20_20_30_30_30}, "left_0_3_repl"};
    tab[7] = '{0, 3, 0, {1'b0, 1'b0, 8'h00, 72'h00_00_10_00_00_20_00_00_30}, "left_0_3_zero"};

    rst_i = 1'b1;
    idle(3);
    check("rst_out_z", {sof_z, in_z, od_z, w_z}, '0);
    check("rst_out_r", {sof_r, in_r, od_r, w_r}, '0);
    check_int("rst_ov", int'(ov_z) + int'(ov_r), 0);
    rst_i = 1'b0;

    slot = 0; cap_en = 1'b1;
    frame(1'b0, 5, 8'h00);
    idle(4);
    cap_en = 1'b0;
    for (int i = 0; i < 8; i++)
      check(tab[i].nm, cap[0][tab[i].dut][tab[i].y][tab[i].x], tab[i].res);

    nin = 0; nout = 0; slot = 1; cap_en = 1'b1;
    frame(1'b1, 5, 8'h00);
    idle(4);
    cap_en = 1'b0;
    check_int("gap_count", nout, nin);
    check_int("gap_nin", nin, 40);
    for (int d = 0; d < 2; d++) begin
      bad = 0;
      for (int y = 0; y < 5; y++)
        for (int x = 0; x < LW; x++)
          if (cap[1][d][y][x] !== cap[0][d][y][x]) bad++;
      check_int(d == 0 ? "gap_vs_cont_z" : "gap_vs_cont_r", bad, 0);
    end

    // Restart the frame at what would have been (3,2); new frame data is offset by 0x80.
    slot = 0; cap_en = 1'b1;
    for (int i = 0; i < 19; i++) drive(1'b1, i == 0, 8'(16*(i/8) + i%8));
    for (int i = 0; i < 24; i++) drive(1'b1, i == 0, 8'h80 + 8'(16*(i/8) + i%8));
    idle(4);
    cap_en = 1'b0;
    check("sof_mid_z", cap[0][0][0][0], {1'b1, 1'b0, 8'h00, 72'h00_00_00_00_00_00_00_00_80});
    check("sof_mid_1_1_z", cap[0][0][1][1], {1'b0, 1'b1, 8'h80, 72'h00_00_00_00_80_81_00_90_91});
    check("sof_mid_1_1_r", cap[0][1][1][1], {1'b0, 1'b1, 8'h80, 72'h80_80_81_80_80_81_90_90_91});
    check("sof_mid_0_1_z", cap[0][0][1][0], {1'b0, 1'b0, 8'h00, 72'h00_00_00_00_00_80_00_00_90});

    // Reset for two cycles while pixels keep streaming.
    slot = 1; cap_en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge iclk);
      if (i == 6 || i == 7) begin
        check("rst_mid_z", {sof_z, in_z, od_z, w_z}, '0);
        check_int("rst_mid_ov", int'(ov_z) + int'(ov_r), 0);
      end
      rst_i  = (i == 5 || i == 6);
      ivalid = 1'b1; isof = 1'b0; idata = 8'hA0 + 8'(i);
    end
    idle(4);
    cap_en = 1'b0;
    check("post_rst_z", cap[1][0][0][0], {1'b0, 1'b0, 8'h00, 72'h00_00_00_00_00_00_00_00_A7});
    check("post_rst_r", cap[1][1][0][0], {1'b0, 1'b0, 8'hA7, 72'hA7_A7_A7_A7_A7_A7_A7_A7_A7});

    // Random data, random gaps, occasional isof.
    drive(1'b1, 1'b1, 8'($urandom));
    for (int i = 0; i < 400; i++) begin
      bit v;
      v = ($urandom_range(0, 9) < 6);
      drive(v, v && ($urandom_range(0, 39) == 0), 8'($urandom));
    end
    idle(4);
    check_int("drain", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
